// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver (and its TX counterpart):
//   - rx_state_t   : receiver FSM state encodings
//   - PAR_EVEN/ODD : parity type encoding on PAR_TYP
//   - DEFAULT_PRESCALE : clocks per bit shared with the transmitter
//   - majority3()  : 2-of-3 vote used by the bit sampler
// ----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEFAULT_PRESCALE = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit oversampling engine. Owns edge_cnt (0..PRESCALE-1 within a bit),
// captures the line at PRESCALE/2-1 and PRESCALE/2, and resolves a 2-of-3
// majority vote with the live sample at PRESCALE/2+1.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   i_rx            serial line (already synchronised if required)
//   i_idle          receiver FSM is in IDLE (edge count held at 0)
//   i_start         start edge seen in IDLE; this clock is edge_cnt = 0
//   o_sampled_bit   voted bit value, valid while o_sample_done is high
//   o_sample_done   strobe: vote resolved this clock (edge_cnt = PRESCALE/2+1)
//   o_bit_done      strobe: last clock of the bit (edge_cnt = PRESCALE-1)
// ----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  input  logic i_idle,
  input  logic i_start,
  output logic o_sampled_bit,
  output logic o_sample_done,
  output logic o_bit_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] C_S0   = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] C_S2   = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_edge_cnt;
  logic [CW-1:0] w_edge_cnt;
  logic [CW-1:0] w_edge_next;
  logic          w_active;
  logic          r_s0;
  logic          r_s1;

  // The register may hold a stale count when the FSM drops back to IDLE
  // mid-bit (after the stop vote); masking it here makes the start-edge
  // clock always read as edge_cnt = 0.
  assign w_edge_cnt = i_idle ? '0 : r_edge_cnt;
  assign w_active   = !i_idle || i_start;

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_edge_next = '0;
    if (w_active && (w_edge_cnt != C_LAST)) begin
      w_edge_next = w_edge_cnt + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
    end else begin
      r_edge_cnt <= w_edge_next;
      if (w_active && (w_edge_cnt == C_S0)) r_s0 <= i_rx;
      if (w_active && (w_edge_cnt == C_S1)) r_s1 <= i_rx;
    end
  end

  assign o_sampled_bit = majority3(r_s0, r_s1, i_rx);
  assign o_sample_done = !i_idle && (w_edge_cnt == C_S2);
  assign o_bit_done    = !i_idle && (w_edge_cnt == C_LAST);

endmodule : uart_rx_sampler

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit (0), DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit (1). Each bit is oversampled PRESCALE times and
// majority-voted by uart_rx_sampler. A frame ends at the stop-bit vote,
// half a bit early, so back-to-back frames are accepted.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset; discards any partial frame
//   RX_IN       serial line, idles high
//   PAR_EN      1 = parity bit present (latched at frame start)
//   PAR_TYP     0 = even, 1 = odd (latched at frame start)
//   P_DATA      received byte, bit 0 = first data bit; updated on good frames
//   data_valid  one-cycle pulse, P_DATA holds a new good byte
//   par_err     one-cycle pulse, parity mismatch in the last frame
//   stp_err     one-cycle pulse, stop bit voted 0
//
// Build option:
//   UART_RX_SYNC_EN  defined: RX_IN passes through a 2-flop synchroniser
//                    (reset to 1); all timing shifts by 2 clocks.
//                    undefined: RX_IN is assumed synchronous to CLK.
// ----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = DEFAULT_PRESCALE,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] C_BIT_LAST = BCW'(DATA_WIDTH - 1);

  logic w_rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], RX_IN};
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = RX_IN;
`endif

  rx_state_t             r_state;
  rx_state_t             w_next;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_vote;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic w_sampled_bit;
  logic w_sample_done;
  logic w_bit_done;
  logic w_idle;
  logic w_start;
  logic w_shift;
  logic w_par_chk;
  logic w_frame_end;
  logic w_par_exp;

  assign w_idle = (r_state == ST_IDLE);

  uart_rx_sampler #(
    .PRESCALE (PRESCALE)
  ) u_sampler (
    .clk           (CLK),
    .rst_n         (RST),
    .i_rx          (w_rx),
    .i_idle        (w_idle),
    .i_start       (w_start),
    .o_sampled_bit (w_sampled_bit),
    .o_sample_done (w_sample_done),
    .o_bit_done    (w_bit_done)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // FSM next state and datapath strobes
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_par_chk   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx) begin
          w_start = 1'b1;
          w_next  = ST_START;
        end
      end
      ST_START: begin
        // A start bit that votes 1 was a glitch: give up at the bit end.
        if (w_bit_done) w_next = r_vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        w_shift = w_sample_done;
        if (w_bit_done && (r_bit_cnt == C_BIT_LAST)) begin
          w_next = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        w_par_chk = w_sample_done;
        if (w_bit_done) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_sample_done) begin
          w_frame_end = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_par_exp = (r_par_typ == PAR_EVEN) ? (^r_data) : (~^r_data);

  // NOTE: the data shift register and P_DATA are reset along with control
  // state, so a reset mid-frame leaves no stale byte visible anywhere.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bit_cnt    <= '0;
      r_data       <= '0;
      r_vote       <= 1'b1;
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_par_bad    <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;

      if (w_sample_done) r_vote <= w_sampled_bit;

      if (w_start) begin
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_par_bad <= 1'b0;
        r_bit_cnt <= '0;
      end

      if (w_shift) r_data[r_bit_cnt] <= w_sampled_bit;
      if ((r_state == ST_DATA) && w_bit_done && (r_bit_cnt != C_BIT_LAST)) begin
        r_bit_cnt <= r_bit_cnt + BCW'(1);
      end

      if (w_par_chk) r_par_bad <= (w_sampled_bit != w_par_exp);

      if (w_frame_end) begin
        r_stp_err    <= ~w_sampled_bit;
        r_par_err    <= r_par_bad;
        r_data_valid <= w_sampled_bit & ~r_par_bad;
        if (w_sampled_bit && !r_par_bad) r_p_data <= r_data;
      end
    end
  end

  assign P_DATA     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

endmodule : uart_rx
